uart_packet_decoder: RTL and testbench

//  Sits directly downstream of the UART byte receiver in sc1_soc. It turns the host loader byte stream into

---
 rtl/uart_packet_decoder_pkg.sv | 16 +
 rtl/uart_packet_decoder_gap_timer.sv | 26 ++
 rtl/uart_packet_decoder.sv | 177 +++++++++++++++++
 tb/tb_uart_packet_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_packet_decoder_pkg.sv
// Shared constants and state encoding for the UART host-loader packet decoder.
// Frame: START, addr[7:0]..addr[31:24], data[7:0]..data[31:24], END.
package uart_packet_decoder_pkg;

    localparam logic [7:0] UART_PKT_START = 8'hAA;
    localparam logic [7:0] UART_PKT_END   = 8'h55;
    localparam int         PKT_BYTES      = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

endpackage

// File: rtl/uart_packet_decoder_gap_timer.sv
// Saturating inter-byte gap counter; o_expired is high while the count is all-ones.
module uart_packet_decoder_gap_timer #(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    assign o_expired = &r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_packet_decoder.sv
// Turns the host-loader byte stream into address/data write commands on a
// valid/ready interface; malformed, timed-out or overrun frames are dropped and flagged.
module uart_packet_decoder
    import uart_packet_decoder_pkg::*;
#(
    parameter int WIDTH_D       = 32,
    parameter int WIDTH_A       = 32,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_A-1:0] out_addr,
    output logic [WIDTH_D-1:0] out_data,
    output logic               busy,
    output logic               err_frame,
    output logic               err_timeout,
    output logic               err_overrun
);

    state_t       r_state;
    state_t       w_state_next;
    logic [1:0]   r_cnt;
    logic [1:0]   w_cnt_next;
    logic [31:0]  r_addr_sr;
    logic [31:0]  r_data_sr;
    logic         w_addr_we;
    logic         w_data_we;
    logic         w_commit;
    logic         w_load;
    logic         w_err_frame_next;
    logic         w_err_timeout_next;
    logic         w_err_overrun_next;
    logic         w_expired;
    logic         w_gap_clear;

    logic               r_out_valid_p1;
    logic [WIDTH_A-1:0] r_out_addr_p1;
    logic [WIDTH_D-1:0] r_out_data_p1;
    logic               r_err_frame_p1;
    logic               r_err_timeout_p1;
    logic               r_err_overrun_p1;

    // The gap counter only runs while a frame is open and restarts on every byte.
    assign w_gap_clear = in_valid || (r_state == ST_IDLE);

    uart_packet_decoder_gap_timer #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_gap_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_gap_clear),
        .i_enable  (1'b1),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_addr_we          = 1'b0;
        w_data_we          = 1'b0;
        w_commit           = 1'b0;
        w_err_frame_next   = 1'b0;
        w_err_timeout_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && (in_data == UART_PKT_START)) begin
                    w_state_next = ST_ADDR;
                    w_cnt_next   = 2'd0;
                end
            end
            ST_ADDR: begin
                if (in_valid) begin
                    w_addr_we  = 1'b1;
                    w_cnt_next = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = ST_DATA;
                    end
                end else if (w_expired) begin
                    w_state_next       = ST_IDLE;
                    w_err_timeout_next = 1'b1;
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    w_data_we  = 1'b1;
                    w_cnt_next = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = ST_TAIL;
                    end
                end else if (w_expired) begin
                    w_state_next       = ST_IDLE;
                    w_err_timeout_next = 1'b1;
                end
            end
            ST_TAIL: begin
                // A START byte here is just a bad tail, never a resync point.
                if (in_valid) begin
                    w_state_next = ST_IDLE;
                    if (in_data == UART_PKT_END) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err_frame_next = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_next       = ST_IDLE;
                    w_err_timeout_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_load             = w_commit && (!r_out_valid_p1 || out_ready);
    assign w_err_overrun_next = w_commit && !w_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_sr <= '0;
            r_data_sr <= '0;
        end else begin
            if (w_addr_we) begin
                r_addr_sr[{r_cnt, 3'b000} +: 8] <= in_data;
            end
            if (w_data_we) begin
                r_data_sr[{r_cnt, 3'b000} +: 8] <= in_data;
            end
        end
    end

    // ---- output stage p1: command register and error pulses ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid_p1   <= 1'b0;
            r_out_addr_p1    <= '0;
            r_out_data_p1    <= '0;
            r_err_frame_p1   <= 1'b0;
            r_err_timeout_p1 <= 1'b0;
            r_err_overrun_p1 <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid_p1 <= 1'b1;
                r_out_addr_p1  <= r_addr_sr[WIDTH_A-1:0];
                r_out_data_p1  <= r_data_sr[WIDTH_D-1:0];
            end else if (r_out_valid_p1 && out_ready) begin
                r_out_valid_p1 <= 1'b0;
            end
            r_err_frame_p1   <= w_err_frame_next;
            r_err_timeout_p1 <= w_err_timeout_next;
            r_err_overrun_p1 <= w_err_overrun_next;
        end
    end

    assign out_valid   = r_out_valid_p1;
    assign out_addr    = r_out_addr_p1;
    assign out_data    = r_out_data_p1;
    assign busy        = (r_state != ST_IDLE);
    assign err_frame   = r_err_frame_p1;
    assign err_timeout = r_err_timeout_p1;
    assign err_overrun = r_err_overrun_p1;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Scoreboard bench for uart_packet_decoder: directed frames push expected commands,
// a negedge monitor pops and compares whenever a new command is presented.
`timescale 1ns/1ps
module tb_uart_packet_decoder;

    localparam int WA = 32;
    localparam int WD = 32;
    localparam int TW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [WA-1:0] out_addr;
    logic [WD-1:0] out_data;
    logic          busy;
    logic          err_frame;
    logic          err_timeout;
    logic          err_overrun;

    uart_packet_decoder #(
        .WIDTH_D       (WD),
        .WIDTH_A       (WA),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   n_frame = 0;
    int   n_tmo   = 0;
    int   n_ovr   = 0;
    int   n_vld   = 0;
    bit   fresh   = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: counts error pulses and checks every newly presented command.
    always @(negedge clk) begin
        if (!reset) begin
            fresh = 1'b1;
        end else begin
            if (err_frame)   n_frame++;
            if (err_timeout) n_tmo++;
            if (err_overrun) n_ovr++;
            if (out_valid) begin
                n_vld++;
                if (fresh) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd", 64'(out_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        cur = exp_q.pop_front();
                        check("cmd_addr", 64'(out_addr), 64'(cur.a));
                        check("cmd_data", 64'(out_data), 64'(cur.d));
                        check("cmd_latency", 64'(cyc), 64'(cur.c));
                    end
                    fresh = 1'b0;
                end
                if (out_ready) begin
                    check("held_addr", 64'(out_addr), 64'(cur.a));
                    check("held_data", 64'(out_data), 64'(cur.d));
                    fresh = 1'b1;
                end
            end
        end
    end

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d,
                              input logic [7:0] tail, input bit expect_cmd, input bit hold);
        logic [7:0] b [10];
        exp_t e;
        b[0] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            b[1+i] = a[8*i +: 8];
            b[5+i] = d[8*i +: 8];
        end
        b[9] = tail;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            @(posedge clk);
            #1;
        end
        if (expect_cmd) begin
            e.a = a;
            e.d = d;
            e.c = cyc;
            exp_q.push_back(e);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int vld0;
    int frame0;
    int tmo0;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", {out_valid, busy, err_frame, err_timeout, err_overrun}, 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        // 1: basic frame, one-cycle out_valid
        vld0 = n_vld;
        send_frame(32'h0000_5000, 32'h0000_0001, 8'h55, 1'b1, 1'b0);
        idle(4);
        check("t1_vld_cycles", 64'(n_vld - vld0), 64'd1);
        check("t1_no_errors", 64'(n_frame + n_tmo + n_ovr), 64'd0);

        // 2: held command, second frame overruns
        out_ready = 1'b0;
        send_frame(32'h0000_4000, 32'h3004_0003, 8'h55, 1'b1, 1'b0);
        idle(3);
        send_frame(32'h0000_4001, 32'h0000_0004, 8'h55, 1'b0, 1'b0);
        check("t2_overrun_pulse", 64'(err_overrun), 64'd1);
        check("t2_still_valid", 64'(out_valid), 64'd1);
        check("t2_held_addr", 64'(out_addr), 64'h4000);
        idle(3);
        out_ready = 1'b1;
        idle(3);
        check("t2_drained", 64'(out_valid), 64'd0);
        check("t2_overrun_count", 64'(n_ovr), 64'd1);

        // 3: leading garbage, then a bad tail
        send_byte(8'h12);
        send_byte(8'h34);
        send_frame(32'h0000_5004, 32'hDEAD_BEEF, 8'h55, 1'b1, 1'b0);
        idle(3);
        frame0 = n_frame;
        vld0   = n_vld;
        send_frame(32'h0000_5005, 32'h1234_5678, 8'h56, 1'b0, 1'b0);
        idle(3);
        check("t3_err_frame", 64'(n_frame - frame0), 64'd1);
        check("t3_no_cmd", 64'(n_vld - vld0), 64'd0);

        // 4: timeout after AA + 3 address bytes
        tmo0 = n_tmo;
        send_byte(8'hAA);
        send_byte(8'h08);
        send_byte(8'h50);
        send_byte(8'h00);
        idle(14);
        check("t4_busy_before", 64'(busy), 64'd1);
        check("t4_no_early_tmo", 64'(n_tmo - tmo0), 64'd0);
        idle(3);
        check("t4_tmo_pulse", 64'(n_tmo - tmo0), 64'd1);
        check("t4_busy_after", 64'(busy), 64'd0);
        send_frame(32'h0000_500C, 32'hCAFE_F00D, 8'h55, 1'b1, 1'b0);
        idle(3);

        // 5: reset during data bytes
        send_byte(8'hAA);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h99);
        send_byte(8'h88);
        reset = 1'b0;
        #2;
        check("t5_rst_ctrl", {out_valid, busy, err_frame, err_timeout, err_overrun}, 64'd0);
        check("t5_rst_addr", 64'(out_addr), 64'd0);
        check("t5_rst_data", 64'(out_data), 64'd0);
        idle(2);
        reset = 1'b1;
        idle(1);
        send_frame(32'h0000_5008, 32'h1122_3344, 8'h55, 1'b1, 1'b0);
        idle(3);

        // 6: two frames back to back
        send_frame(32'h0000_4010, 32'hA5A5_5A5A, 8'h55, 1'b1, 1'b1);
        send_frame(32'h0000_4014, 32'h0102_0304, 8'h55, 1'b1, 1'b0);
        idle(4);

        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        check("end_err_frame", 64'(n_frame), 64'd1);
        check("end_err_timeout", 64'(n_tmo), 64'd1);
        check("end_err_overrun", 64'(n_ovr), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
